// File: rtl/cnn_win_fsm_if.sv
// Configuration, backpressure and window-index bundle between the register file,
// the window sequencer and the line-buffer/MAC datapath. CNN_WIN_FSM_ABORT_EN adds i_abort.
interface cnn_win_fsm_if #(
  parameter int unsigned W_SIZE       = 12,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int unsigned W_DELAY      = 12,
  parameter int unsigned W_K          = 3,
  parameter int unsigned W_TAP        = 5,
  parameter int unsigned W_CH         = 4
);
  logic [W_K-1:0]          q_kernel_size;
  logic [W_CH-1:0]         q_num_ch;
  logic [W_SIZE-1:0]       q_width;
  logic [W_SIZE-1:0]       q_height;
  logic [W_DELAY-1:0]      q_start_up_delay;
  logic [W_DELAY-1:0]      q_hsync_delay;
  logic [W_FRAME_SIZE-1:0] q_frame_size;
  logic                    q_start;
  logic                    i_stall;
`ifdef CNN_WIN_FSM_ABORT_EN
  logic                    i_abort;
`endif

  logic                    o_ctrl_vsync_run;
  logic [W_DELAY-1:0]      o_ctrl_vsync_cnt;
  logic                    o_ctrl_hsync_run;
  logic [W_DELAY-1:0]      o_ctrl_hsync_cnt;
  logic                    o_ctrl_data_run;
  logic                    o_pix_valid;
  logic [W_SIZE-1:0]       o_row;
  logic [W_SIZE-1:0]       o_col;
  logic [W_CH-1:0]         o_ch;
  logic [W_K-1:0]          o_kx;
  logic [W_K-1:0]          o_ky;
  logic [W_TAP-1:0]        o_pix_idx;
  logic                    o_pix_last;
  logic [W_FRAME_SIZE-1:0] o_data_count;
  logic                    o_end_frame;
  logic                    o_frame_done;
  logic                    o_busy;

  modport master (
`ifdef CNN_WIN_FSM_ABORT_EN
    output i_abort,
`endif
    output q_kernel_size, q_num_ch, q_width, q_height, q_start_up_delay, q_hsync_delay,
    output q_frame_size, q_start, i_stall,
    input  o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
    input  o_ctrl_data_run, o_pix_valid, o_row, o_col, o_ch, o_kx, o_ky, o_pix_idx,
    input  o_pix_last, o_data_count, o_end_frame, o_frame_done, o_busy
  );

  modport slave (
`ifdef CNN_WIN_FSM_ABORT_EN
    input  i_abort,
`endif
    input  q_kernel_size, q_num_ch, q_width, q_height, q_start_up_delay, q_hsync_delay,
    input  q_frame_size, q_start, i_stall,
    output o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
    output o_ctrl_data_run, o_pix_valid, o_row, o_col, o_ch, o_kx, o_ky, o_pix_idx,
    output o_pix_last, o_data_count, o_end_frame, o_frame_done, o_busy
  );
endinterface

// File: rtl/cnn_win_fsm.sv
// Frame/window sequencer: vsync/hsync/data phases plus row, col, channel and KxK tap indices.
// Define CNN_WIN_FSM_ABORT_EN to add the i_abort early-termination input.
module cnn_win_fsm #(
  parameter int unsigned W_SIZE       = 12,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int unsigned W_DELAY      = 12,
  parameter int unsigned MAX_K        = 5,
  parameter int unsigned W_K          = 3,
  parameter int unsigned W_TAP        = 5,
  parameter int unsigned W_CH         = 4
) (
  input logic          clk,
  input logic          rst,
  cnn_win_fsm_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StVsync, StHsync, StData} state_e;

  state_e                  state_q, state_d;
  logic [W_DELAY-1:0]      vsync_cnt_q, vsync_cnt_d;
  logic [W_DELAY-1:0]      hsync_cnt_q, hsync_cnt_d;
  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_CH-1:0]         ch_q, ch_d;
  logic [W_K-1:0]          kx_q, kx_d;
  logic [W_K-1:0]          ky_q, ky_d;
  logic [W_TAP-1:0]        pix_idx_q, pix_idx_d;
  logic [W_FRAME_SIZE-1:0] data_count_q, data_count_d;
  logic                    frame_done_q, frame_done_d;
  logic [W_K-1:0]          k_q, k_d;
  logic [W_CH-1:0]         num_ch_q, num_ch_d;
  logic [W_SIZE-1:0]       width_q, width_d;
  logic [W_FRAME_SIZE-1:0] frame_size_q, frame_size_d;

  logic [W_TAP-1:0] k_tap;
  logic [W_TAP-1:0] kk_last;
  logic [W_K-1:0]   k_last;
  logic             k_ok;
  logic             step, tap_last, ch_last, pix_last, adv, col_last, end_frame, abort;
  logic             unused_height;

  // Height is implied by the latched frame size; kept on the bundle for the register file.
  assign unused_height = ^bus.q_height;

  always_comb begin
    k_tap     = W_TAP'(k_q);
    kk_last   = k_tap * k_tap - W_TAP'(1);
    k_last    = k_q - W_K'(1);
    k_ok      = bus.q_kernel_size[0] && (bus.q_kernel_size <= W_K'(MAX_K));
    step      = (state_q == StData) && !bus.i_stall;
    tap_last  = (pix_idx_q == kk_last);
    ch_last   = (ch_q == num_ch_q - W_CH'(1));
    pix_last  = tap_last && ch_last;
    adv       = step && pix_last;
    col_last  = (col_q == width_q - W_SIZE'(1));
    end_frame = (data_count_q == frame_size_q - W_FRAME_SIZE'(1));
`ifdef CNN_WIN_FSM_ABORT_EN
    abort     = bus.i_abort && (state_q != StIdle);
`else
    abort     = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    ch_d         = ch_q;
    kx_d         = kx_q;
    ky_d         = ky_q;
    pix_idx_d    = pix_idx_q;
    data_count_d = data_count_q;
    frame_done_d = 1'b0;
    k_d          = k_q;
    num_ch_d     = num_ch_q;
    width_d      = width_q;
    frame_size_d = frame_size_q;

    unique case (state_q)
      StIdle: begin
        if (bus.q_start) begin
          state_d      = StVsync;
          k_d          = k_ok ? bus.q_kernel_size : W_K'(1);
          num_ch_d     = (bus.q_num_ch == '0) ? W_CH'(1) : bus.q_num_ch;
          width_d      = bus.q_width;
          frame_size_d = bus.q_frame_size;
        end
      end
      StVsync: if (vsync_cnt_q == bus.q_start_up_delay) state_d = StHsync;
      StHsync: if (hsync_cnt_q == bus.q_hsync_delay) state_d = StData;
      StData: begin
        if (adv) begin
          if (end_frame) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end else if (col_last) begin
            state_d = StHsync;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Nesting innermost first: kx, ky (flat pix_idx alongside), channel, then pixel.
    if (step) begin
      kx_d      = (kx_q == k_last) ? '0 : kx_q + W_K'(1);
      pix_idx_d = tap_last ? '0 : pix_idx_q + W_TAP'(1);
      if (kx_q == k_last) ky_d = (ky_q == k_last) ? '0 : ky_q + W_K'(1);
      if (tap_last) ch_d = ch_last ? '0 : ch_q + W_CH'(1);
      if (pix_last) begin
        col_d = col_last ? '0 : col_q + W_SIZE'(1);
        if (end_frame) begin
          row_d        = '0;
          data_count_d = '0;
        end else begin
          if (col_last) row_d = row_q + W_SIZE'(1);
          data_count_d = data_count_q + W_FRAME_SIZE'(1);
        end
      end
    end

    if (abort) begin
      state_d      = StIdle;
      frame_done_d = 1'b0;
      row_d        = '0;
      col_d        = '0;
      ch_d         = '0;
      kx_d         = '0;
      ky_d         = '0;
      pix_idx_d    = '0;
      data_count_d = '0;
    end

    // Sync counters restart from zero on every entry into their phase.
    vsync_cnt_d = ((state_q == StVsync) && (state_d == StVsync)) ?
                  vsync_cnt_q + W_DELAY'(1) : '0;
    hsync_cnt_d = ((state_q == StHsync) && (state_d == StHsync)) ?
                  hsync_cnt_q + W_DELAY'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      vsync_cnt_q  <= '0;
      hsync_cnt_q  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ch_q         <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      pix_idx_q    <= '0;
      data_count_q <= '0;
      frame_done_q <= 1'b0;
      k_q          <= '0;
      num_ch_q     <= '0;
      width_q      <= '0;
      frame_size_q <= '0;
    end else begin
      state_q      <= state_d;
      vsync_cnt_q  <= vsync_cnt_d;
      hsync_cnt_q  <= hsync_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ch_q         <= ch_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      pix_idx_q    <= pix_idx_d;
      data_count_q <= data_count_d;
      frame_done_q <= frame_done_d;
      k_q          <= k_d;
      num_ch_q     <= num_ch_d;
      width_q      <= width_d;
      frame_size_q <= frame_size_d;
    end
  end

  assign bus.o_ctrl_vsync_run = (state_q == StVsync);
  assign bus.o_ctrl_vsync_cnt = vsync_cnt_q;
  assign bus.o_ctrl_hsync_run = (state_q == StHsync);
  assign bus.o_ctrl_hsync_cnt = hsync_cnt_q;
  assign bus.o_ctrl_data_run  = (state_q == StData);
  assign bus.o_pix_valid      = step;
  assign bus.o_row            = row_q;
  assign bus.o_col            = col_q;
  assign bus.o_ch             = ch_q;
  assign bus.o_kx             = kx_q;
  assign bus.o_ky             = ky_q;
  assign bus.o_pix_idx        = pix_idx_q;
  assign bus.o_pix_last       = pix_last && (state_q == StData);
  assign bus.o_data_count     = data_count_q;
  assign bus.o_end_frame      = end_frame;
  assign bus.o_frame_done     = frame_done_q;
  assign bus.o_busy           = (state_q != StIdle);

endmodule

// File: tb/tb_cnn_win_fsm.sv
// Scoreboard bench for cnn_win_fsm: expected tap streams are queued at frame start and
// popped by a monitor on every o_pix_valid cycle; phase, stall, reset and abort checked inline.
module tb_cnn_win_fsm;

  typedef struct packed {
    logic [11:0] row;
    logic [11:0] col;
    logic [3:0]  ch;
    logic [2:0]  kx;
    logic [2:0]  ky;
    logic [4:0]  idx;
    logic        last;
    logic [24:0] dc;
    logic        ef;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cnn_win_fsm_if bus ();

  cnn_win_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] outs();
    return {bus.o_ctrl_vsync_run, bus.o_ctrl_vsync_cnt, bus.o_ctrl_hsync_run,
            bus.o_ctrl_hsync_cnt, bus.o_ctrl_data_run, bus.o_pix_valid, bus.o_row, bus.o_col,
            bus.o_ch, bus.o_kx, bus.o_ky, bus.o_pix_idx, bus.o_pix_last, bus.o_data_count,
            bus.o_end_frame, bus.o_frame_done, bus.o_busy};
  endfunction

  // Monitor: every presented tap must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!rst && bus.o_pix_valid) begin
      got = '{row: bus.o_row, col: bus.o_col, ch: bus.o_ch, kx: bus.o_kx, ky: bus.o_ky,
              idx: bus.o_pix_idx, last: bus.o_pix_last, dc: bus.o_data_count,
              ef: bus.o_end_frame};
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 128'(exp_q.size()), 128'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_tap", 128'(got), 128'(e));
      end
    end
  end

  task automatic push_frame(input int k, input int n, input int w, input int h);
    exp_t e;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int ch = 0; ch < n; ch++)
          for (int y = 0; y < k; y++)
            for (int x = 0; x < k; x++) begin
              e.row  = 12'(r);
              e.col  = 12'(c);
              e.ch   = 4'(ch);
              e.kx   = 3'(x);
              e.ky   = 3'(y);
              e.idx  = 5'(y * k + x);
              e.last = (x == k - 1) && (y == k - 1) && (ch == n - 1);
              e.dc   = 25'(r * w + c);
              e.ef   = (r * w + c) == (w * h - 1);
              exp_q.push_back(e);
            end
  endtask

  task automatic set_cfg(input int qk, input int qn, input int w, input int h,
                         input int sud, input int hd);
    bus.q_kernel_size    = 3'(qk);
    bus.q_num_ch         = 4'(qn);
    bus.q_width          = 12'(w);
    bus.q_height         = 12'(h);
    bus.q_frame_size     = 25'(w * h);
    bus.q_start_up_delay = 12'(sud);
    bus.q_hsync_delay    = 12'(hd);
  endtask

  task automatic run_frame(input int qk, input int qn, input int w, input int h,
                           input int sud, input int hd, input int ek, input int en,
                           output int vs, output int hs, output int ds, output int dn,
                           output int vmax, output int hmax);
    int cyc;
    vs = 0; hs = 0; ds = 0; dn = 0; vmax = 0; hmax = 0; cyc = 0;
    @(negedge clk);
    set_cfg(qk, qn, w, h, sud, hd);
    push_frame(ek, en, w, h);
    bus.q_start = 1'b1;
    @(negedge clk);
    bus.q_start = 1'b0;
    while (cyc < 5000) begin
      if (bus.o_ctrl_vsync_run) begin
        vs++;
        if (int'(bus.o_ctrl_vsync_cnt) > vmax) vmax = int'(bus.o_ctrl_vsync_cnt);
      end
      if (bus.o_ctrl_hsync_run) begin
        hs++;
        if (int'(bus.o_ctrl_hsync_cnt) > hmax) hmax = int'(bus.o_ctrl_hsync_cnt);
      end
      if (bus.o_ctrl_data_run) ds++;
      if (bus.o_frame_done) begin
        dn++;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.o_frame_done) dn++;
    end
  endtask

  task automatic wait_done(output int dn);
    dn = 0;
    for (int i = 0; i < 500 && dn == 0; i++) begin
      @(negedge clk);
      if (bus.o_frame_done) dn = 1;
    end
  endtask

  task automatic stall_proc();
    int cyc = 0;
    while (!(bus.o_ctrl_data_run && bus.o_pix_idx == 5'd4) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t3_stall_point", {bus.o_ctrl_data_run, bus.o_pix_idx}, {1'b1, 5'd4});
    bus.i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_stall_frozen",
          {bus.o_ctrl_data_run, bus.o_pix_valid, bus.o_pix_idx, bus.o_kx, bus.o_ky, bus.o_ch,
           bus.o_col, bus.o_data_count},
          {1'b1, 1'b0, 5'd4, 3'd1, 3'd1, 4'd0, 12'd0, 25'd0});
    end
    bus.i_stall = 1'b0;
  endtask

  task automatic change_mid();
    int cyc = 0;
    while (!bus.o_ctrl_data_run && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.q_kernel_size = 3'd5;
    bus.q_num_ch      = 4'd2;
    bus.q_width       = 12'd3;
    bus.q_frame_size  = 25'd6;
  endtask

  initial begin
    int vs, hs, ds, dn, vm, hm;
    int cyc;
    set_cfg(0, 0, 0, 0, 0, 0);
    bus.q_start = 1'b0;
    bus.i_stall = 1'b0;
`ifdef CNN_WIN_FSM_ABORT_EN
    bus.i_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_outs_held", outs(), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs_idle", outs(), 128'd0);

    // K=1, one channel, 4x2, delays 2/1
    run_frame(1, 1, 4, 2, 2, 1, 1, 1, vs, hs, ds, dn, vm, hm);
    chk("t1_vsync_cycles", 128'(vs), 128'd3);
    chk("t1_hsync_cycles", 128'(hs), 128'd4);
    chk("t1_data_cycles", 128'(ds), 128'd8);
    chk("t1_done_pulses", 128'(dn), 128'd1);
    chk("t1_vsync_cnt_max", 128'(vm), 128'd2);
    chk("t1_hsync_cnt_max", 128'(hm), 128'd1);
    chk("t1_sb_drained", 128'(exp_q.size()), 128'd0);
    chk("t1_idle", 128'(bus.o_busy), 128'd0);

    // K=3, two channels, 2x1
    run_frame(3, 2, 2, 1, 0, 0, 3, 2, vs, hs, ds, dn, vm, hm);
    chk("t2_vsync_cycles", 128'(vs), 128'd1);
    chk("t2_hsync_cycles", 128'(hs), 128'd1);
    chk("t2_data_cycles", 128'(ds), 128'd36);
    chk("t2_done_pulses", 128'(dn), 128'd1);
    chk("t2_sb_drained", 128'(exp_q.size()), 128'd0);

    // K=3 with a 5-cycle stall at tap 4
    fork
      run_frame(3, 1, 2, 1, 1, 0, 3, 1, vs, hs, ds, dn, vm, hm);
      stall_proc();
    join
    chk("t3_data_cycles", 128'(ds), 128'd23);
    chk("t3_done_pulses", 128'(dn), 128'd1);
    chk("t3_sb_drained", 128'(exp_q.size()), 128'd0);

    // Illegal K=4 / num_ch=0 sanitised to 1/1; mid-frame config changes ignored
    fork
      run_frame(4, 0, 6, 2, 0, 0, 1, 1, vs, hs, ds, dn, vm, hm);
      change_mid();
    join
    chk("t4_data_cycles", 128'(ds), 128'd12);
    chk("t4_done_pulses", 128'(dn), 128'd1);
    chk("t4_sb_drained", 128'(exp_q.size()), 128'd0);
    run_frame(5, 1, 2, 1, 0, 0, 5, 1, vs, hs, ds, dn, vm, hm);
    chk("t4_k5_data_cycles", 128'(ds), 128'd50);
    chk("t4_k5_sb_drained", 128'(exp_q.size()), 128'd0);

    // Asynchronous reset at row 1, col 2, then immediate restart
    @(negedge clk);
    set_cfg(1, 1, 4, 2, 0, 0);
    push_frame(1, 1, 4, 2);
    bus.q_start = 1'b1;
    @(negedge clk);
    bus.q_start = 1'b0;
    cyc = 0;
    while (!(bus.o_ctrl_data_run && bus.o_row == 12'd1 && bus.o_col == 12'd2) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_mid_point", {bus.o_ctrl_data_run, bus.o_row, bus.o_col}, {1'b1, 12'd1, 12'd2});
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", outs(), 128'd0);
    exp_q.delete();
    push_frame(1, 1, 4, 2);
    bus.q_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_restart_vsync", {bus.o_ctrl_vsync_run, bus.o_ctrl_vsync_cnt, bus.o_busy},
        {1'b1, 12'd0, 1'b1});
    bus.q_start = 1'b0;
    wait_done(dn);
    chk("t5_restart_done", 128'(dn), 128'd1);
    chk("t5_sb_drained", 128'(exp_q.size()), 128'd0);

`ifdef CNN_WIN_FSM_ABORT_EN
    // Abort during the hsync phase of line 1
    @(negedge clk);
    set_cfg(1, 1, 4, 2, 1, 2);
    push_frame(1, 1, 4, 2);
    bus.q_start = 1'b1;
    @(negedge clk);
    bus.q_start = 1'b0;
    cyc = 0;
    while (!(bus.o_ctrl_hsync_run && bus.o_row == 12'd1) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t6_abort_point", {bus.o_ctrl_hsync_run, bus.o_row}, {1'b1, 12'd1});
    bus.i_abort = 1'b1;
    @(posedge clk); #1;
    chk("t6_abort_outs", outs(), 128'd0);
    bus.i_abort = 1'b0;
    @(posedge clk); #1;
    chk("t6_no_done", 128'(bus.o_frame_done), 128'd0);
    exp_q.delete();
    run_frame(1, 1, 4, 2, 1, 2, 1, 1, vs, hs, ds, dn, vm, hm);
    chk("t6_clean_data_cycles", 128'(ds), 128'd8);
    chk("t6_clean_done", 128'(dn), 128'd1);
    chk("t6_sb_drained", 128'(exp_q.size()), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cnn_win_fsm.md
Name: cnn_win_fsm

Overview:
- Parametrised frame/window sequencer for the CNN accelerator. It generates vsync/hsync/data phases plus row, column, channel and kernel-tap indices for KxK convolution windows (K = 1, 3, 5, ... up to MAX_K) over multi-channel input.
- Adds downstream backpressure (stall) and a one-cycle frame-done pulse.
- Sits between the AHB register file (q_* configuration) and the line-buffer/MAC datapath.

Parameters:
- W_SIZE, 12, width of row/col and width/height fields.
- W_FRAME_SIZE, 2*W_SIZE+1, width of frame-size and data-count fields.
- W_DELAY, 12, width of delay fields and sync counters.
- MAX_K, 5, largest supported odd kernel size.
- W_K, 3, width of kernel-size field and kx/ky indices.
- W_TAP, 5, width of flat tap index; must satisfy 2^W_TAP >= MAX_K*MAX_K.
- W_CH, 4, width of channel-count field and channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- q_kernel_size  in  W_K  kernel size K.
- q_num_ch  in  W_CH  input channels per pixel.
- q_width  in  W_SIZE  pixels per line.
- q_height  in  W_SIZE  lines per frame.
- q_start_up_delay  in  W_DELAY  vsync phase length minus 1.
- q_hsync_delay  in  W_DELAY  hsync phase length minus 1.
- q_frame_size  in  W_FRAME_SIZE  width*height.
- q_start  in  1  frame start request (level, sampled in IDLE).
- i_stall  in  1  downstream not ready; freezes data counters.
- o_ctrl_vsync_run  out  1  in VSYNC.
- o_ctrl_vsync_cnt  out  W_DELAY  vsync counter.
- o_ctrl_hsync_run  out  1  in HSYNC.
- o_ctrl_hsync_cnt  out  W_DELAY  hsync counter.
- o_ctrl_data_run  out  1  in DATA.
- o_pix_valid  out  1  data_run & !i_stall.
- o_row  out  W_SIZE  current line.
- o_col  out  W_SIZE  current pixel.
- o_ch  out  W_CH  current channel.
- o_kx  out  W_K  tap column, 0..K-1.
- o_ky  out  W_K  tap row, 0..K-1.
- o_pix_idx  out  W_TAP  flat tap index, ky*K+kx.
- o_pix_last  out  1  last tap of last channel of the current pixel.
- o_data_count  out  W_FRAME_SIZE  pixels completed in frame.
- o_end_frame  out  1  data_count == q_frame_size-1.
- o_frame_done  out  1  one-cycle pulse on DATA->IDLE.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE. All counters, indices, o_frame_done and latched configuration are 0. o_end_frame is combinational and reflects data_count=0.
- Configuration latch: q_kernel_size, q_num_ch, q_width and q_frame_size are latched on the IDLE->VSYNC transition. q_* changes mid-frame have no effect.
- Kernel-size sanitising: K of 0, even, or >MAX_K is latched as 1.
- Channel sanitising: num_ch of 0 is latched as 1.
- Delay fields are read live.
- States IDLE, VSYNC, HSYNC, DATA:
  - IDLE->VSYNC when q_start=1. q_start is ignored in every other state.
  - VSYNC->HSYNC when vsync_cnt==q_start_up_delay, so VSYNC lasts delay+1 cycles.
  - HSYNC->DATA when hsync_cnt==q_hsync_delay.
  - DATA->IDLE on a pixel advance with end_frame=1.
  - DATA->HSYNC on a pixel advance with col==width-1.
  - Otherwise DATA holds.
- Sync counters increment while their run flag is set and clear otherwise. i_stall has no effect on them.
- Step: a cycle in DATA with i_stall=0.
- Tap/channel/pixel nesting, innermost first:
  - kx increments on each step and wraps at K-1.
  - ky increments on kx wrap and wraps at K-1.
  - pix_idx increments on each step and clears at K*K-1.
  - ch increments on tap wrap and wraps at num_ch-1.
  - Pixel advance = step & pix_last, where pix_last = (pix_idx==K*K-1)&(ch==num_ch-1).
- Pixel advance effects:
  - col increments, or clears at width-1.
  - row increments at col==width-1, or clears if end_frame.
  - data_count increments, or clears if end_frame.
- K=1, num_ch=1: one pixel per step, with no gaps.
- Stall: every data-path index holds, including across end of line and end of frame. FSM stays in DATA; o_pix_valid=0.
- o_frame_done is registered. It is 1 for exactly the first IDLE cycle after a frame.
- Back-to-back frames: q_start held high re-enters VSYNC the cycle after IDLE.
- Width rules: all counters are unsigned. Comparisons use width-1 and frame_size-1 computed at field width. width=0 or frame_size=0 is illegal, and behaviour for it is undefined.

Optional Feature:
- Macro CNN_WIN_FSM_ABORT_EN.
- Defined:
  - Adds input i_abort (1 bit).
  - i_abort=1 in any non-IDLE state forces IDLE next cycle and clears all counters/indices. No o_frame_done pulse.
  - i_abort has priority over i_stall and over normal transitions. It is ignored in IDLE.
- Undefined: the port is absent. A frame can only end via end_frame or rst.

Test Plan:
- K=1, num_ch=1, width=4, height=2, frame_size=8, delays 2/1:
  - 3 VSYNC cycles, 2 HSYNC cycles, 4 DATA cycles, repeated per line.
  - data_count reaches 7, then IDLE; o_frame_done pulses once.
- K=3, num_ch=2, width=2, height=1:
  - 18 steps per pixel; pix_idx 0..8 twice per pixel with ch 0 then 1.
  - o_pix_last high only at pix_idx=8, ch=1; col advances 0->1.
- K=3, i_stall high 5 cycles at pix_idx=4:
  - All indices frozen, o_pix_valid=0 for 5 cycles.
  - Sequence resumes at pix_idx=4 with no tap lost or duplicated.
- q_kernel_size=4 and q_num_ch=0:
  - Behaves as K=1, num_ch=1.
  - q_kernel_size changed to 5 mid-frame has no effect until the next start.
- rst asserted mid-DATA (row=1, col=2):
  - All outputs 0 and IDLE immediately.
  - With q_start=1 after release, VSYNC begins the next cycle.
- With CNN_WIN_FSM_ABORT_EN, i_abort in HSYNC of line 1:
  - IDLE next cycle, counters 0, no o_frame_done.
  - A following q_start runs a full clean frame.
